// File: rtl/booth_seq_mul_pkg.sv
// Shared types and radix-16 Booth digit encoder for the signed multipliers.
// Any parallel multiplier can reuse booth_enc16 so both agree on digit coding.
package mul_pkg;

  localparam int WIDTH = 16;
  localparam int NDIG  = WIDTH / 4;

  typedef enum logic [3:0] {
    PP_0  = 4'd0,
    PP_A  = 4'd1,
    PP_2A = 4'd2,
    PP_3A = 4'd3,
    PP_4A = 4'd4,
    PP_5A = 4'd5,
    PP_6A = 4'd6,
    PP_7A = 4'd7,
    PP_8A = 4'd8
  } booth_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    booth_sel_t sel;
    logic       neg;
  } booth_dig_t;

  // w[4:1] read as a signed nibble is -8*w4+4*w3+2*w2+w1; w[0] adds the overlap bit.
  function automatic booth_dig_t booth_enc16(input logic [4:0] w);
    booth_dig_t  r;
    logic [4:0]  d;
    d     = {w[4], w[4:1]} + {4'b0000, w[0]};
    r.neg = d[4];
    r.sel = booth_sel_t'(d[4] ? 4'(5'd0 - d) : d[3:0]);
    return r;
  endfunction

endpackage

// File: rtl/booth_seq_mul_if.sv
// Operand/result handshake bundle for booth_seq_mul.
interface booth_seq_mul_if;
  import mul_pkg::*;

  logic                   valid_in;
  logic                   ready_out;
  logic [WIDTH-1:0]       multiplicand_in;
  logic [WIDTH-1:0]       multiplier_in;
  logic                   valid_out;
  logic                   ready_in;
  logic [2*WIDTH-1:0]     product_out;
  logic                   busy_out;

  modport master (
    output valid_in, multiplicand_in, multiplier_in, ready_in,
    input  ready_out, valid_out, product_out, busy_out
  );

  modport slave (
    input  valid_in, multiplicand_in, multiplier_in, ready_in,
    output ready_out, valid_out, product_out, busy_out
  );

endinterface

// File: rtl/booth_seq_mul_pp_gen.sv
// Booth partial-product generator: selects 0..8 x A and returns it one's-complemented
// when negative; the +1 that completes the negation is added by the accumulator.
module pp_gen
  import mul_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  booth_sel_t       sel,
  input  logic             neg,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] a1, a2, a4, a8, mag;

  assign a1 = {{3{a[WIDTH-1]}}, a};
  assign a2 = a1 << 1;
  assign a4 = a1 << 2;
  assign a8 = a1 << 3;

  always_comb begin
    mag = '0;
    case (sel)
      PP_0:    mag = '0;
      PP_A:    mag = a1;
      PP_2A:   mag = a2;
      PP_3A:   mag = a2 + a1;
      PP_4A:   mag = a4;
      PP_5A:   mag = a4 + a1;
      PP_6A:   mag = a4 + a2;
      PP_7A:   mag = a8 - a1;
      PP_8A:   mag = a8;
      default: mag = '0;
    endcase
  end

  // Inverting instead of negating keeps -8 * (-2^(WIDTH-1)) representable in WIDTH+3 bits.
  assign pp = mag ^ {(WIDTH+3){neg}};

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-16 Booth signed multiplier: one digit per cycle into a 2*WIDTH accumulator.
//   state | meaning
//   IDLE  | waiting for an operand pair
//   BUSY  | accumulating digit cnt_q of the multiplier
//   DONE  | product_out valid, held until the sink takes it
module booth_seq_mul
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  booth_seq_mul_if.slave    bus
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW = WIDTH + 3;

  mul_state_t           state, state_nxt;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q, prod_q, acc_nxt, pp_ext, cin_ext;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH:0]       b_ext;
  logic [4:0]           win;
  logic [CW+1:0]        shamt;
  booth_dig_t           dig;
  logic [PW-1:0]        pp;
  logic                 accept, last;

  assign accept = bus.valid_in && bus.ready_out;
  assign last   = (cnt_q == CW'(NDIG - 1));
  assign shamt  = {cnt_q, 2'b00};

  // B[-1] = 0 is supplied by the appended zero bit.
  assign b_ext = {b_q, 1'b0};
  assign win   = b_ext[shamt +: 5];
  assign dig   = booth_enc16(win);

  pp_gen u_pp_gen (
    .a   (a_q),
    .sel (dig.sel),
    .neg (dig.neg),
    .pp  (pp)
  );

  assign pp_ext  = {{(2*WIDTH-PW){pp[PW-1]}}, pp};
  assign cin_ext = {{(2*WIDTH-1){1'b0}}, dig.neg};
  assign acc_nxt = acc_q + (pp_ext << shamt) + (cin_ext << shamt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (bus.ready_in) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_out = 1'b0;
    bus.valid_out = 1'b0;
    bus.busy_out  = 1'b0;
    case (state)
      IDLE: bus.ready_out = 1'b1;
      BUSY: bus.busy_out  = 1'b1;
      DONE: begin
        bus.valid_out = 1'b1;
        bus.ready_out = bus.ready_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_q   <= bus.multiplicand_in;
      b_q   <= bus.multiplier_in;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state == BUSY) begin
      acc_q <= acc_nxt;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (last) prod_q <= acc_nxt;
    end
  end

  assign bus.product_out = prod_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed and random-stream bench for booth_seq_mul at WIDTH = 16.
module tb_booth_seq_mul;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  booth_seq_mul_if bus();

  booth_seq_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues one operand pair from IDLE with ready_in high, returns product and latency, ends in IDLE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int lat);
    bus.multiplicand_in = a;
    bus.multiplier_in   = b;
    bus.valid_in        = 1'b1;
    step;
    bus.valid_in = 1'b0;
    lat = 0;
    while (!bus.valid_out && lat < 50) begin
      step;
      lat++;
    end
    p = bus.product_out;
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    bus.multiplicand_in = '0;
    bus.multiplier_in   = '0;
    repeat (2) step;
    checks++;
    if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_out); end
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
    checks++;
    if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_out); end
    checks++;
    if (bus.product_out !== 32'h0) begin errors++; $display("FAIL reset_product: got %h expected 00000000", bus.product_out); end
    rst = 1'b0;
    step;
    checks++;
    if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got ready=%b valid=%b expected ready=1 valid=0", bus.ready_out, bus.valid_out);
    end
  endtask

  task automatic test_basic;
    logic [31:0] p;
    int lat;
    run_op(16'd3, 16'd5, p, lat);
    checks++;
    if (p !== 32'h0000000F) begin errors++; $display("FAIL basic_product: got %h expected 0000000f", p); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++;
    if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      errors++; $display("FAIL basic_back_to_idle: got ready=%b valid=%b busy=%b expected 1 0 0",
                         bus.ready_out, bus.valid_out, bus.busy_out);
    end
  endtask

  task automatic test_extremes;
    logic [15:0] ta [3] = '{16'h8000, 16'h7FFF, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h8000, 16'h7FFF, 16'h0001};
    logic [31:0] te [3] = '{32'h40000000, 32'h3FFF0001, 32'hFFFFFFFF};
    logic [31:0] p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], p, lat);
      checks++;
      if (p !== te[i]) begin
        errors++; $display("FAIL extremes_%0d: A=%h B=%h got %h expected %h", i, ta[i], tb[i], p, te[i]);
      end
    end
  endtask

  task automatic test_neg_digits;
    logic [15:0] ta [2] = '{16'h0001, 16'h1234};
    logic [15:0] tb [2] = '{16'h8888, 16'h0000};
    logic [31:0] te [2] = '{32'hFFFF8888, 32'h00000000};
    logic [31:0] p;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], tb[i], p, lat);
      checks++;
      if (p !== te[i]) begin
        errors++; $display("FAIL neg_digits_%0d: A=%h B=%h got %h expected %h", i, ta[i], tb[i], p, te[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad_hold = 0;
    bus.ready_in        = 1'b0;
    bus.multiplicand_in = 16'h0102;
    bus.multiplier_in   = 16'h0304;
    bus.valid_in        = 1'b1;
    step;
    bus.multiplicand_in = 16'hFFFE;
    bus.multiplier_in   = 16'h0010;
    lat = 0;
    while (!bus.valid_out && lat < 50) begin
      step;
      lat++;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_first_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.product_out !== 32'h00030A08 || bus.ready_out !== 1'b0 || bus.valid_out !== 1'b1) begin
        errors++; bad_hold++;
        $display("FAIL bp_hold_%0d: got product=%h ready=%b valid=%b expected 00030a08 0 1",
                 i, bus.product_out, bus.ready_out, bus.valid_out);
      end
      step;
    end
    bus.ready_in = 1'b1;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_follow: got %b expected 1", bus.ready_out); end
    step;
    bus.valid_in = 1'b0;
    checks++;
    if (bus.busy_out !== 1'b1 || bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL bp_no_bubble: got busy=%b valid=%b expected 1 0", bus.busy_out, bus.valid_out);
    end
    checks++;
    if (bus.product_out !== 32'h00030A08) begin
      errors++; $display("FAIL bp_product_busy: got %h expected 00030a08", bus.product_out);
    end
    lat = 0;
    while (!bus.valid_out && lat < 50) begin
      step;
      lat++;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_second_latency: got %0d expected 4", lat); end
    checks++;
    if (bus.product_out !== 32'hFFFFFFE0) begin
      errors++; $display("FAIL bp_second_product: got %h expected ffffffe0", bus.product_out);
    end
    step;
  endtask

  task automatic test_reset_mid;
    logic [31:0] p;
    int lat;
    int pulses = 0;
    bus.multiplicand_in = 16'h0101;
    bus.multiplier_in   = 16'h0101;
    bus.valid_in        = 1'b1;
    step;
    bus.valid_in = 1'b0;
    repeat (2) step;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl: got ready=%b valid=%b busy=%b expected 1 0 0",
                         bus.ready_out, bus.valid_out, bus.busy_out);
    end
    checks++;
    if (bus.product_out !== 32'h0) begin
      errors++; $display("FAIL mid_reset_product: got %h expected 00000000", bus.product_out);
    end
    repeat (2) step;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.valid_out === 1'b1) pulses++;
      step;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL mid_reset_no_result: got %0d valid cycles expected 0", pulses); end
    run_op(16'hFFFD, 16'd7, p, lat);
    checks++;
    if (p !== 32'hFFFFFFEB) begin errors++; $display("FAIL mid_reset_next: got %h expected ffffffeb", p); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL mid_reset_latency: got %0d expected 4", lat); end
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(9))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic test_random;
    localparam int N = 10000;
    logic [31:0]        expq [$];
    logic [31:0]        e;
    logic signed [31:0] ref_p;
    logic [15:0]        ca = '0;
    logic [15:0]        cb = '0;
    bit                 have = 1'b0;
    int                 sent = 0;
    int                 got = 0;
    int                 cyc = 0;
    int                 bad = 0;
    while (got < N && cyc < 90000) begin
      if (!have && sent < N) begin
        ca = rnd_op();
        cb = rnd_op();
        have = 1'b1;
      end
      bus.multiplicand_in = ca;
      bus.multiplier_in   = cb;
      bus.valid_in        = have && ($urandom_range(7) != 0);
      bus.ready_in        = ($urandom_range(7) != 0);
      #1;
      if (bus.valid_out && bus.ready_in) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL random_extra: got result %h expected none outstanding", bus.product_out);
        end else begin
          e = expq.pop_front();
          got++;
          if (bus.product_out !== e) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL random_%0d: got %h expected %h", got, bus.product_out, e);
          end
        end
      end
      if (bus.valid_in && bus.ready_out) begin
        ref_p = $signed(ca) * $signed(cb);
        expq.push_back(ref_p);
        sent++;
        have = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    checks++;
    if (got !== N) begin errors++; $display("FAIL random_count: got %0d results expected %0d", got, N); end
    checks++;
    if (expq.size() !== 0) begin errors++; $display("FAIL random_outstanding: got %0d left expected 0", expq.size()); end
    repeat (8) step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_neg_digits;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
